audio_pwm_dac_nch: RTL

N-channel PWM audio DAC and the parametrised successor of the fixed 2×9-bit PWM audio outputs. It accepts a frame of signed PCM samples per channel through a valid/ready handshake and double-buffers it. New frames are applied only at PWM period boundaries, so duty changes are glitch-free. It handles mute and underrun explicitly. It sits between the APU left/right mix and the audio_l/audio_r pins, or any wider channel set.

---
 rtl/audio_pwm_dac_nch_if.sv | 22 ++
 rtl/audio_pwm_dac_nch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_dac_nch_if.sv
// audio_pwm_dac_nch_if: frame handshake bundle for the PWM audio DAC.
// One frame carries CHANNELS signed samples, channel k at [k*IN_WIDTH +: IN_WIDTH].
interface audio_pwm_dac_nch_if #(
    parameter int CHANNELS = 2,
    parameter int IN_WIDTH = 16
);
    logic                         s_valid;
    logic                         s_ready;
    logic [CHANNELS*IN_WIDTH-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/audio_pwm_dac_nch.sv
// audio_pwm_dac_nch: N-channel PWM audio DAC.
// Frames of signed PCM samples are double-buffered and only applied at PWM
// period wraps, so duty changes never produce runt pulses. Mute forces
// midscale; a wrap with no pending frame keeps the old duties and flags underrun.
// Define AUDIO_PWM_DAC_NOISESHAPE_EN to carry the truncated sample LSBs in a
// per-channel error accumulator (first-order noise shaping, needs
// IN_WIDTH > PWM_WIDTH). Without it the samples are plainly truncated.
module audio_pwm_dac_nch #(
    parameter int CHANNELS  = 2,
    parameter int IN_WIDTH  = 16,
    parameter int PWM_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    audio_pwm_dac_nch_if.slave    frame,
    input  logic                  mute,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_strobe,
    output logic                  underrun
);

    localparam logic [PWM_WIDTH-1:0] MIDSCALE = PWM_WIDTH'(1) << (PWM_WIDTH - 1);
    localparam logic [PWM_WIDTH-1:0] DUTY_MAX = '1;

    logic [PWM_WIDTH-1:0]         cnt;
    logic                         wrap;
    logic                         accept;
    logic                         pending_full;
    logic                         pending_full_next;
    logic [CHANNELS*IN_WIDTH-1:0] pending;
    logic [PWM_WIDTH-1:0]         duty [CHANNELS];

    // Signed top bits to offset binary: flipping the sign bit maps
    // most-negative to 0, zero to midscale and most-positive to full scale.
    function automatic logic [PWM_WIDTH-1:0] to_offset(input logic signed [PWM_WIDTH-1:0] top);
        return $unsigned(top) ^ MIDSCALE;
    endfunction

    assign wrap   = (cnt == DUTY_MAX);
    assign accept = frame.s_valid && frame.s_ready;

    // Pending buffer occupancy: any wrap empties it (transfer or mute drop),
    // an accept fills it. Accept only happens while empty, so both cannot collide
    // on a full buffer; an accept on the wrap cycle stays pending for one period.
    always_comb begin
        pending_full_next = pending_full;
        if (wrap && pending_full) begin
            pending_full_next = 1'b0;
        end
        if (accept) begin
            pending_full_next = 1'b1;
        end
    end

    // Control state: period counter, buffer flag, registered ready and wrap pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            pending_full  <= 1'b0;
            frame.s_ready <= 1'b0;
            period_strobe <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            cnt           <= cnt + 1'b1;
            pending_full  <= pending_full_next;
            frame.s_ready <= !pending_full_next;
            period_strobe <= wrap;
            underrun      <= wrap && !mute && !pending_full;
        end
    end

    // Pending frame data; only the flag is reset, the data is qualified by it.
    always_ff @(posedge clk) begin
        if (accept) begin
            pending <= frame.s_data;
        end
    end

`ifdef AUDIO_PWM_DAC_NOISESHAPE_EN
    localparam int FRAC_W = IN_WIDTH - PWM_WIDTH;

    logic [CHANNELS*IN_WIDTH-1:0] held;
    logic [CHANNELS*IN_WIDTH-1:0] src;
    logic [FRAC_W-1:0]            err [CHANNELS];
    logic [FRAC_W:0]              acc_sum [CHANNELS];
    logic [PWM_WIDTH-1:0]         shaped [CHANNELS];

    // Add the accumulator carry to the duty without wrapping past full scale.
    function automatic logic [PWM_WIDTH-1:0] sat_inc(input logic [PWM_WIDTH-1:0] base,
                                                     input logic carry);
        if (carry && (base == DUTY_MAX)) begin
            return DUTY_MAX;
        end
        return base + PWM_WIDTH'(carry);
    endfunction

    assign src = pending_full ? pending : held;

    // Per-channel shaped duty: top bits in offset binary plus the carry out of
    // accumulating the discarded LSBs.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            acc_sum[k] = {1'b0, err[k]} + {1'b0, src[k*IN_WIDTH +: FRAC_W]};
            shaped[k]  = sat_inc(to_offset(src[(k+1)*IN_WIDTH-PWM_WIDTH +: PWM_WIDTH]),
                                 acc_sum[k][FRAC_W]);
        end
    end

    // Active duties, accumulators and the held frame, updated only at wraps.
    // The held frame is re-shaped on underrun so the dither keeps running;
    // mute clears it to zero so later underruns stay at midscale.
    always_ff @(posedge clk) begin
        if (rst) begin
            held <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                duty[k] <= MIDSCALE;
                err[k]  <= '0;
            end
        end else if (wrap) begin
            if (mute) begin
                held <= '0;
                for (int k = 0; k < CHANNELS; k++) begin
                    duty[k] <= MIDSCALE;
                    err[k]  <= '0;
                end
            end else begin
                if (pending_full) begin
                    held <= pending;
                end
                for (int k = 0; k < CHANNELS; k++) begin
                    duty[k] <= shaped[k];
                    err[k]  <= acc_sum[k][FRAC_W-1:0];
                end
            end
        end
    end
`else
    logic [PWM_WIDTH-1:0] converted [CHANNELS];
    logic                 unused_pending;

    // Sample LSBs below the PWM resolution are only consumed by noise shaping.
    assign unused_pending = ^pending;

    // Truncating conversion of the pending frame.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            converted[k] = to_offset(pending[(k+1)*IN_WIDTH-PWM_WIDTH +: PWM_WIDTH]);
        end
    end

    // Active duties, updated only at wraps; underrun leaves them unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                duty[k] <= MIDSCALE;
            end
        end else if (wrap) begin
            if (mute) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    duty[k] <= MIDSCALE;
                end
            end else if (pending_full) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    duty[k] <= converted[k];
                end
            end
        end
    end
`endif

    // PWM comparators, registered; a duty loaded at the wrap first shows at cnt=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                pwm_out[k] <= (cnt < duty[k]);
            end
        end
    end

endmodule
